// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, a two-entry skid buffer so
// that up_ready_o is a pure flop output, synchronous flush and saturating counters.
module pipe_stage_skid #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter int                CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [PC_W-1:0]   PC_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [PC_W-1:0]   PC_o,
  output logic [INST_W-1:0] inst_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_up_ready;
  logic                r_dn_valid;
  logic [PC_W-1:0]     r_main_pc;
  logic [INST_W-1:0]   r_main_inst;
  logic [PC_W-1:0]     r_skid_pc;
  logic [INST_W-1:0]   r_skid_inst;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic                w_accept;
  logic                w_pop;
  logic                w_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Handshake qualifiers, all derived from registered outputs
  always_comb begin
    w_accept = up_valid_i & r_up_ready;
    w_pop    = r_dn_valid & dn_ready_i;
    w_stall  = r_dn_valid & ~dn_ready_i;
  end

  // Stage FSM: main/skid storage, registered valid and ready
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_EMPTY;
      r_up_ready  <= 1'b1;
      r_dn_valid  <= 1'b0;
      r_main_pc   <= {PC_W{1'b0}};
      r_main_inst <= NOP_INST;
      r_skid_pc   <= {PC_W{1'b0}};
      r_skid_inst <= NOP_INST;
    end else if (flush_i) begin
      // A pop this cycle still completes downstream; any accepted beat is dropped
      r_state     <= ST_EMPTY;
      r_up_ready  <= 1'b1;
      r_dn_valid  <= 1'b0;
      r_main_inst <= NOP_INST;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_ONE;
            r_dn_valid  <= 1'b1;
            r_main_pc   <= PC_i;
            r_main_inst <= inst_i;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_main_pc   <= PC_i;
            r_main_inst <= inst_i;
          end else if (w_accept) begin
            r_state     <= ST_FULL;
            r_up_ready  <= 1'b0;
            r_skid_pc   <= PC_i;
            r_skid_inst <= inst_i;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_dn_valid  <= 1'b0;
            r_main_inst <= NOP_INST;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state     <= ST_ONE;
            r_up_ready  <= 1'b1;
            r_main_pc   <= r_skid_pc;
            r_main_inst <= r_skid_inst;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_up_ready  <= 1'b1;
          r_dn_valid  <= 1'b0;
          r_main_inst <= NOP_INST;
        end
      endcase
    end
  end

  // Stall counter: head valid but held off by downstream
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  // Flush counter: one count per sampled flush cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_flush_cnt <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign up_ready_o  = r_up_ready;
  assign dn_valid_o  = r_dn_valid;
  assign PC_o        = r_main_pc;
  assign inst_o      = r_main_inst;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the pipelined CPU (IF/ID and subsequent stage boundaries), replacing the plain write-enabled register pair. Carries a PC and instruction word across a stage boundary with a valid/ready handshake, a two-entry skid buffer so that `up_ready_o` is fully registered, synchronous flush with NOP bubble insertion, and saturating stall/flush performance counters.

## Interface
- `PC_W`, 32, PC field width
- `INST_W`, 32, instruction field width
- `NOP_INST`, 32'h00000013, instruction presented when the stage is empty or flushed (`addi x0,x0,0`)
- `CNT_W`, 16, width of the performance counters

- `clk_i`  in  1  clock; all state changes on its rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `flush_i`  in  1  discard all held entries at the next edge
- `up_valid_i`  in  1  upstream beat valid
- `up_ready_o`  out  1  stage can accept a beat (registered)
- `PC_i`  in  PC_W  upstream PC
- `inst_i`  in  INST_W  upstream instruction
- `dn_valid_o`  out  1  `PC_o`/`inst_o` hold a live beat
- `dn_ready_i`  in  1  downstream accepts the beat
- `PC_o`  out  PC_W  PC of head entry
- `inst_o`  out  INST_W  instruction of head entry, `NOP_INST` when not valid
- `stall_cnt_o`  out  CNT_W  cycles with `dn_valid_o`=1 and `dn_ready_i`=0, saturating
- `flush_cnt_o`  out  CNT_W  cycles with `flush_i`=1 sampled, saturating

## Operation
- Storage: head entry (`main`, drives outputs) and `skid` entry, each with a valid bit.
- Handshakes: accept = `up_valid_i` & `up_ready_o`; pop = `dn_valid_o` & `dn_ready_i`. A beat transfers only when both valid and ready are high; `PC_i`/`inst_i` are sampled only on accept.
- `up_ready_o` = !skid.valid, driven from a flop. No combinational path from `dn_ready_i` to `up_ready_o`.
- States: EMPTY (main and skid invalid), ONE (main valid), FULL (main and skid valid).
- EMPTY: accept -> ONE, main <= input.
- ONE: accept & pop -> ONE, main <= input. Accept & !pop -> FULL, skid <= input. !accept & pop -> EMPTY. Otherwise hold.
- FULL: `up_ready_o`=0. Pop -> ONE, main <= skid. Otherwise hold.
- Beat order is strictly FIFO. No beat is dropped or duplicated except on flush.
- Flush takes priority over everything else:
  - Next state is EMPTY, and both valid bits clear.
  - A beat accepted in the flush cycle is consumed and discarded.
  - A pop in the flush cycle completes normally; the downstream keeps that beat.
- `inst_o` = `NOP_INST` whenever `dn_valid_o`=0.
- `PC_o` holds its last value when the stage goes empty, whether by pop or flush.
- Counters increment by 1 per qualifying cycle and stick at 2^CNT_W−1. They are cleared only by reset.

## Timing
- Reset (async assert, any cycle, including mid-transfer):
  - `dn_valid_o`=0, `up_ready_o`=1, `PC_o`=0, `inst_o`=`NOP_INST`.
  - Both counters 0, state EMPTY, skid contents don't-care.
- Reset release is synchronous to `clk_i`; the first accept is possible on the first edge after deassertion.
- Latency: beat accepted at edge N appears with `dn_valid_o`=1 after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained while `dn_ready_i`=1.
- Backpressure: `dn_ready_i` low absorbs exactly one extra beat into skid. `up_ready_o` falls the cycle after skid fills and rises the cycle after skid drains.
- `flush_i` at edge N: `dn_valid_o`=0 and `up_ready_o`=1 in cycle N+1.
- Downstream rule: the stage never deasserts `dn_valid_o` or changes `PC_o`/`inst_o` while `dn_valid_o`=1 and `dn_ready_i`=0, except on flush or reset.

## Test plan
- Reset then stream PC 0x0,0x4,0x8 with `dn_ready_i`=1 -> each appears one cycle after accept, in order; `stall_cnt_o`=0, `up_ready_o` stays 1.
- Accept PC 0x10 (inst 0x00500093), hold `dn_ready_i`=0 while offering 0x14 and 0x18:
  - 0x14 lands in skid; `up_ready_o`=0 the next cycle, so 0x18 is not accepted.
  - Outputs hold 0x10 stable.
  - Release `dn_ready_i` -> 0x10, 0x14, 0x18 in order; `stall_cnt_o` equals the number of stalled cycles.
- FULL state plus `flush_i`=1 for one cycle -> next cycle `dn_valid_o`=0, `inst_o`=0x00000013, `up_ready_o`=1; `flush_cnt_o`=1; neither held beat ever emerges.
- Flush concurrent with accept of PC 0x20 and pop of head -> popped beat counted as delivered, 0x20 discarded, stage EMPTY.
- `CNT_W`=4, hold stall for 20 cycles -> `stall_cnt_o` saturates at 15 and stays there.
- Assert `rst_i` low mid-stream while FULL -> outputs go to reset values immediately without a clock edge; after release the stream restarts cleanly.
